// File: rtl/param_updown_counter.sv
// Bus-programmable up/down cycle counter with bounce/wrap modes, abort, busy flag and readback.
// Optional prescaler on address 6 is enabled by defining COUNTER_PRESCALE_EN.
module param_updown_counter #(
  parameter int WIDTH     = 8,
  parameter int CCR_WIDTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 ncs,
  input  logic                 nrd,
  input  logic                 nwr,
  input  logic [2:0]           addr,
  inout  wire  [WIDTH-1:0]     data_in_out,
  input  logic                 start_in,
  output logic [WIDTH-1:0]     count,
  output logic                 err,
  output logic                 ec,
  output logic                 dir,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UP     = 2'd1,
    ST_DOWN   = 2'd2,
    ST_RETURN = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]     ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CCR_WIDTH-1:0] REM_ONE = {{(CCR_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic limits_ok(input logic [WIDTH-1:0] plr, input logic [WIDTH-1:0] ulr,
                                     input logic [WIDTH-1:0] llr);
    return (llr <= plr) && (plr <= ulr);
  endfunction

  state_t                state_r, state_n;
  logic [WIDTH-1:0]      count_r, count_n;
  logic [CCR_WIDTH-1:0]  rem_r, rem_n;
  logic                  wrapped_r, wrapped_n;
  logic                  dir_r, dir_n;
  logic                  busy_r, busy_n;
  logic                  ec_r, ec_n;
  logic                  err_r, err_n;
  logic                  run_mode_r, run_mode_n;
  logic [WIDTH-1:0]      plr_r, ulr_r, llr_r;
  logic [CCR_WIDTH-1:0]  ccr_r;
  logic                  mode_r;
  logic                  wr_en_s, rd_en_s, step_en_s, abort_s, prot_addr_s, cfg_err_s, cycle_done_s;
  logic [WIDTH-1:0]      rd_data_s;

  assign wr_en_s   = !ncs && !nwr && nrd;
  assign rd_en_s   = !ncs && !nrd && nwr;
  assign abort_s   = wr_en_s && busy_r && (addr == 3'd4) && data_in_out[1];
  assign cfg_err_s = wr_en_s && busy_r && prot_addr_s;

`ifdef COUNTER_PRESCALE_EN
  logic [WIDTH-1:0] psr_r, pre_cnt_r;
  assign step_en_s   = (pre_cnt_r == psr_r);
  assign prot_addr_s = (addr <= 3'd3) || (addr == 3'd6);

  // Prescaler: held at zero while idle so every run starts with a fresh interval
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pre_cnt_r <= {WIDTH{1'b0}};
    end else if (!busy_r || step_en_s) begin
      pre_cnt_r <= {WIDTH{1'b0}};
    end else begin
      pre_cnt_r <= pre_cnt_r + ONE_W;
    end
  end
`else
  assign step_en_s   = 1'b1;
  assign prot_addr_s = (addr <= 3'd3);
`endif

  // Configuration registers; limit registers are frozen while a run is in progress
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      plr_r  <= {WIDTH{1'b0}};
      ulr_r  <= {WIDTH{1'b1}};
      llr_r  <= {WIDTH{1'b0}};
      ccr_r  <= {CCR_WIDTH{1'b0}};
      mode_r <= 1'b0;
`ifdef COUNTER_PRESCALE_EN
      psr_r  <= {WIDTH{1'b0}};
`endif
    end else if (wr_en_s) begin
      case (addr)
        3'd0:    if (!busy_r) plr_r <= data_in_out;
        3'd1:    if (!busy_r) ulr_r <= data_in_out;
        3'd2:    if (!busy_r) llr_r <= data_in_out;
        3'd3:    if (!busy_r) ccr_r <= data_in_out[CCR_WIDTH-1:0];
        3'd4:    mode_r <= data_in_out[0];
`ifdef COUNTER_PRESCALE_EN
        3'd6:    if (!busy_r) psr_r <= data_in_out;
`endif
        default: mode_r <= mode_r;
      endcase
    end
  end

  // Readback multiplexer
  always_comb begin
    rd_data_s = {WIDTH{1'b0}};
    case (addr)
      3'd0:    rd_data_s = plr_r;
      3'd1:    rd_data_s = ulr_r;
      3'd2:    rd_data_s = llr_r;
      3'd3:    rd_data_s = WIDTH'(ccr_r);
      3'd4:    rd_data_s[0] = mode_r;
      3'd5:    rd_data_s = count_r;
`ifdef COUNTER_PRESCALE_EN
      3'd6:    rd_data_s = psr_r;
`endif
      3'd7:    rd_data_s[3:0] = {mode_r, dir_r, err_r, busy_r};
      default: rd_data_s = {WIDTH{1'b0}};
    endcase
  end

  assign data_in_out = rd_en_s ? rd_data_s : {WIDTH{1'bz}};

  // Next-state logic: stepping, cycle completion, then error and abort overrides
  always_comb begin
    state_n      = state_r;
    count_n      = count_r;
    rem_n        = rem_r;
    wrapped_n    = wrapped_r;
    dir_n        = dir_r;
    busy_n       = busy_r;
    ec_n         = 1'b0;
    err_n        = err_r;
    run_mode_n   = run_mode_r;
    cycle_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!start_in) begin
          state_n = ST_IDLE;
        end else if (!limits_ok(plr_r, ulr_r, llr_r)) begin
          err_n = 1'b1;
        end else if (ccr_r == {CCR_WIDTH{1'b0}}) begin
          ec_n = 1'b1;
        end else begin
          count_n    = plr_r;
          rem_n      = ccr_r;
          run_mode_n = mode_r;
          wrapped_n  = 1'b0;
          err_n      = 1'b0;
          busy_n     = 1'b1;
          dir_n      = 1'b1;
          state_n    = ST_UP;
        end
      end
      ST_UP: begin
        if (!step_en_s) begin
          state_n = ST_UP;
        end else if (run_mode_r) begin
          if (wrapped_r && (count_r == plr_r)) begin
            cycle_done_s = 1'b1;
          end else if (count_r < ulr_r) begin
            count_n = count_r + ONE_W;
          end else begin
            count_n   = llr_r;
            wrapped_n = 1'b1;
          end
        end else if (count_r < ulr_r) begin
          count_n = count_r + ONE_W;
        end else begin
          state_n = ST_DOWN;
          dir_n   = 1'b0;
        end
      end
      ST_DOWN: begin
        if (!step_en_s) begin
          state_n = ST_DOWN;
        end else if (count_r > llr_r) begin
          count_n = count_r - ONE_W;
        end else begin
          state_n = ST_RETURN;
          dir_n   = 1'b1;
        end
      end
      ST_RETURN: begin
        if (!step_en_s) begin
          state_n = ST_RETURN;
        end else if (count_r < plr_r) begin
          count_n = count_r + ONE_W;
        end else begin
          cycle_done_s = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
        dir_n   = 1'b1;
      end
    endcase

    if (!cycle_done_s) begin
      rem_n = rem_n;
    end else if (rem_r == REM_ONE) begin
      ec_n    = 1'b1;
      busy_n  = 1'b0;
      dir_n   = 1'b1;
      state_n = ST_IDLE;
    end else begin
      rem_n     = rem_r - REM_ONE;
      wrapped_n = 1'b0;
      state_n   = ST_UP;
    end

    if (cfg_err_s) begin
      err_n = 1'b1;
    end else begin
      err_n = err_n;
    end

    if (abort_s) begin
      state_n   = ST_IDLE;
      count_n   = count_r;
      rem_n     = rem_r;
      wrapped_n = 1'b0;
      busy_n    = 1'b0;
      ec_n      = 1'b0;
      dir_n     = 1'b1;
    end else begin
      state_n = state_n;
    end
  end

  // Counter state register
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_r    <= ST_IDLE;
      count_r    <= {WIDTH{1'b0}};
      rem_r      <= {CCR_WIDTH{1'b0}};
      wrapped_r  <= 1'b0;
      dir_r      <= 1'b1;
      busy_r     <= 1'b0;
      ec_r       <= 1'b0;
      err_r      <= 1'b0;
      run_mode_r <= 1'b0;
    end else begin
      state_r    <= state_n;
      count_r    <= count_n;
      rem_r      <= rem_n;
      wrapped_r  <= wrapped_n;
      dir_r      <= dir_n;
      busy_r     <= busy_n;
      ec_r       <= ec_n;
      err_r      <= err_n;
      run_mode_r <= run_mode_n;
    end
  end

  assign count = count_r;
  assign err   = err_r;
  assign ec    = ec_r;
  assign dir   = dir_r;
  assign busy  = busy_r;

endmodule

// File: tb/tb_param_updown_counter.sv
// Scoreboard bench for param_updown_counter: stimulus queues expectations, a negedge monitor compares.
module tb_param_updown_counter;

  localparam int K_CNT = 0, K_EC = 1, K_BUSY = 2, K_DIR = 3, K_ERR = 4, K_BUS = 5;

  typedef struct {
    string      name;
    int         kind;
    logic [7:0] exp;
  } chk_t;

  logic       clk_in = 1'b0;
  logic       reset_in = 1'b0;
  logic       ncs = 1'b1, nrd = 1'b1, nwr = 1'b1;
  logic [2:0] addr = 3'd0;
  logic       start_in = 1'b0;
  logic       tb_drv = 1'b0;
  logic [7:0] tb_dat = 8'd0;
  wire  [7:0] data_in_out;
  logic [7:0] count;
  logic       err, ec, dir, busy;

  chk_t       sb_q[$];
  chk_t       cur;
  logic [7:0] act;
  int         n_pass = 0;
  int         n_chk = 0;

  assign data_in_out = tb_drv ? tb_dat : 8'bz;

  param_updown_counter #(.WIDTH(8), .CCR_WIDTH(8)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .ncs(ncs), .nrd(nrd), .nwr(nwr), .addr(addr),
    .data_in_out(data_in_out), .start_in(start_in), .count(count), .err(err), .ec(ec),
    .dir(dir), .busy(busy)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: drain every queued expectation against the DUT on the falling edge
  always @(negedge clk_in) begin
    while (sb_q.size() > 0) begin
      cur = sb_q.pop_front();
      case (cur.kind)
        K_CNT:   act = count;
        K_EC:    act = {7'd0, ec};
        K_BUSY:  act = {7'd0, busy};
        K_DIR:   act = {7'd0, dir};
        K_ERR:   act = {7'd0, err};
        default: act = data_in_out;
      endcase
      n_chk++;
      if (act === cur.exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", cur.name, act, cur.exp, $time);
    end
  end

  task automatic expect_val(input string n, input int k, input logic [7:0] v);
    chk_t c;
    c.name = n;
    c.kind = k;
    c.exp  = v;
    sb_q.push_back(c);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    addr = a; tb_dat = d; tb_drv = 1'b1; ncs = 1'b0; nwr = 1'b0; nrd = 1'b1;
    tick();
    ncs = 1'b1; nwr = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [7:0] v, input string n);
    addr = a; ncs = 1'b0; nrd = 1'b0; nwr = 1'b1;
    expect_val(n, K_BUS, v);
    @(negedge clk_in);
    #1;
    ncs = 1'b1; nrd = 1'b1;
  endtask

  task automatic do_start();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  initial begin
    int bnc_cnt[11] = '{6, 7, 7, 6, 5, 4, 3, 3, 4, 5, 5};
    int bnc_dir[11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    int wrp_cnt[5]  = '{3, 4, 1, 2, 2};
    int idx;

    // Reset values
    repeat (2) tick();
    expect_val("rst_count", K_CNT, 8'h00);
    expect_val("rst_err", K_ERR, 8'h00);
    expect_val("rst_ec", K_EC, 8'h00);
    expect_val("rst_dir", K_DIR, 8'h01);
    expect_val("rst_busy", K_BUSY, 8'h00);
    tick();
    reset_in = 1'b1;
    tick();

    // Readback
    bus_write(3'd0, 8'hA5);
    bus_read(3'd0, 8'hA5, "rd_plr");
    bus_read(3'd1, 8'hFF, "rd_ulr_rst");

    // Bounce: two cycles of 11 steps
    bus_write(3'd0, 8'd5);
    bus_write(3'd1, 8'd7);
    bus_write(3'd2, 8'd3);
    bus_write(3'd3, 8'd2);
    bus_write(3'd4, 8'd0);
    do_start();
    expect_val("bnc_start_cnt", K_CNT, 8'd5);
    expect_val("bnc_start_busy", K_BUSY, 8'd1);
    expect_val("bnc_start_dir", K_DIR, 8'd1);
    for (int k = 1; k <= 22; k++) begin
      tick();
      if (k == 16) begin
        ncs = 1'b1; nrd = 1'b1;
      end
      idx = (k - 1) % 11;
      expect_val("bnc_cnt", K_CNT, 8'(bnc_cnt[idx]));
      expect_val("bnc_dir", K_DIR, 8'(bnc_dir[idx]));
      expect_val("bnc_ec", K_EC, (k == 22) ? 8'd1 : 8'd0);
      expect_val("bnc_busy", K_BUSY, (k == 22) ? 8'd0 : 8'd1);
      if (k == 15) begin
        addr = 3'd7; ncs = 1'b0; nrd = 1'b0; nwr = 1'b1;
        expect_val("rd_status_bnc", K_BUS, 8'h01);
      end
    end
    tick();
    expect_val("bnc_ec_single", K_EC, 8'd0);
    expect_val("bnc_hold_plr", K_CNT, 8'd5);

    // Wrap: 5 steps, dir stays 1
    bus_write(3'd0, 8'd2);
    bus_write(3'd1, 8'd4);
    bus_write(3'd2, 8'd1);
    bus_write(3'd3, 8'd1);
    bus_write(3'd4, 8'd1);
    do_start();
    expect_val("wrp_start_cnt", K_CNT, 8'd2);
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_val("wrp_cnt", K_CNT, 8'(wrp_cnt[k-1]));
      expect_val("wrp_dir", K_DIR, 8'd1);
      expect_val("wrp_ec", K_EC, (k == 5) ? 8'd1 : 8'd0);
      expect_val("wrp_busy", K_BUSY, (k == 5) ? 8'd0 : 8'd1);
    end

    // Limit violation
    bus_write(3'd0, 8'd9);
    bus_write(3'd1, 8'd7);
    do_start();
    expect_val("bad_err", K_ERR, 8'd1);
    expect_val("bad_busy", K_BUSY, 8'd0);
    expect_val("bad_count", K_CNT, 8'd2);

    // Valid start clears err, busy write sets it, abort at count 6
    bus_write(3'd0, 8'd5);
    bus_write(3'd2, 8'd3);
    bus_write(3'd3, 8'd2);
    bus_write(3'd4, 8'd0);
    do_start();
    expect_val("ok_err_clr", K_ERR, 8'd0);
    expect_val("ok_busy", K_BUSY, 8'd1);
    bus_write(3'd1, 8'h20);
    expect_val("busy_wr_err", K_ERR, 8'd1);
    expect_val("busy_wr_cnt", K_CNT, 8'd6);
    bus_write(3'd4, 8'h02);
    expect_val("abort_cnt", K_CNT, 8'd6);
    expect_val("abort_busy", K_BUSY, 8'd0);
    expect_val("abort_ec", K_EC, 8'd0);
    expect_val("abort_dir", K_DIR, 8'd1);
    tick();
    expect_val("abort_hold", K_CNT, 8'd6);
    expect_val("abort_no_ec", K_EC, 8'd0);
    bus_read(3'd1, 8'd7, "ulr_unchanged");

    // CCR = 0
    bus_write(3'd3, 8'd0);
    do_start();
    expect_val("ccr0_ec", K_EC, 8'd1);
    expect_val("ccr0_busy", K_BUSY, 8'd0);
    tick();
    expect_val("ccr0_ec_end", K_EC, 8'd0);

    // Asynchronous reset mid-count
    bus_write(3'd3, 8'd2);
    do_start();
    repeat (3) tick();
    #2;
    reset_in = 1'b0;
    #1;
    expect_val("mid_rst_cnt", K_CNT, 8'd0);
    expect_val("mid_rst_busy", K_BUSY, 8'd0);
    expect_val("mid_rst_dir", K_DIR, 8'd1);
    expect_val("mid_rst_err", K_ERR, 8'd0);
    tick();
    reset_in = 1'b1;
    tick();
    bus_read(3'd0, 8'd0, "mid_rst_plr");
    bus_read(3'd1, 8'hFF, "mid_rst_ulr");

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk_in);
    #1;
    if (sb_q.size() > 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/param_updown_counter.md
Name: param_updown_counter

Overview:
- Parametrised, bus-programmable up/down cycle counter with a chip-select/read/write register interface and a bidirectional data bus.
- Counts between programmable lower and upper limits, starting from a programmable preload value, for a programmed number of cycles.
- Adds over the 8-bit counter: configurable width, a selectable bounce or wrap mode, abort, a busy flag, and readback of count and status.
- Sits on the peripheral bus as a timing/sequence source for downstream logic.

Parameters:
- WIDTH, 8, width of the data bus, PLR, ULR, LLR and count.
- CCR_WIDTH, 8, width of the cycle count register CCR and the remaining-cycle counter (CCR_WIDTH <= WIDTH).

Ports:
- clk_in  in  1  clock, rising edge.
- reset_in  in  1  asynchronous active-low reset.
- ncs  in  1  chip select, active low.
- nrd  in  1  read strobe, active low.
- nwr  in  1  write strobe, active low.
- addr  in  3  register select.
- data_in_out  inout  WIDTH  bidirectional data bus.
- start_in  in  1  start request, sampled only in IDLE.
- count  out  WIDTH  current count.
- err  out  1  sticky configuration/access error.
- ec  out  1  end-of-count pulse.
- dir  out  1  1 = counting up, 0 = counting down.
- busy  out  1  high while counting.

Behaviour:
- Reset (async, reset_in=0): PLR=0, ULR=all ones, LLR=0, CCR=0, CTRL=0, count=0, err=0, ec=0, dir=1, busy=0, state IDLE, bus released.
- Register map: 0 PLR, 1 ULR, 2 LLR, 3 CCR (zero-extended), 4 CTRL (bit0 mode: 0 bounce, 1 wrap; bit1 abort, write-only, self-clearing), 5 count (read-only), 6 PSR (see optional feature), 7 STATUS (bit0 busy, bit1 err, bit2 dir, bit3 mode, rest 0).
- Write:
  - Commits on the clk_in edge where ncs=0, nwr=0 and nrd=1.
  - Writes to addresses 0-3 while busy=1 are ignored and set err.
  - Writes to read-only addresses are ignored, with no error.
- Read: data_in_out is driven combinationally while ncs=0, nrd=0 and nwr=1; it is high-Z otherwise. nrd=0 and nwr=0 together: no read and no write.
- States: IDLE, UP, DOWN, RETURN.
- IDLE, start_in=1:
  - LLR<=PLR<=ULR violated: err=1, stay in IDLE.
  - CCR=0: ec pulses 1 clock, stay in IDLE.
  - Otherwise: count<=PLR, rem<=CCR, mode latched from CTRL, err cleared, busy=1, dir=1, next state UP.
- Bounce mode (one step per step-enable):
  - UP: count<ULR -> +1; count=ULR -> dwell, go to DOWN, dir=0.
  - DOWN: count>LLR -> -1; count=LLR -> dwell, go to RETURN, dir=1.
  - RETURN: count<PLR -> +1; count=PLR -> cycle complete.
  - Cycle length is 2*(ULR-LLR)+3 steps.
- Wrap mode (dir stays 1):
  - UP: count<ULR -> +1; count=ULR -> count<=LLR and the wrapped flag is set.
  - Wrapped and count=PLR -> cycle complete.
  - Cycle length is ULR-LLR+2 steps.
- Cycle complete:
  - rem=1: ec pulses 1 clock, busy=0, go to IDLE, count holds PLR.
  - Otherwise: rem-1, wrapped cleared, go to UP (count holds one step).
- Abort: a CTRL write with bit1=1 while busy sends the counter to IDLE on the next edge. count holds, no ec, dir=1.
- Simultaneous events: abort beats cycle completion. start_in outside IDLE is ignored. A reset mid-count returns to the reset values immediately.
- Arithmetic: unsigned WIDTH bits. The limit checks guarantee no overflow or underflow.

Optional Feature:
- COUNTER_PRESCALE_EN defined:
  - Address 6 is PSR (WIDTH bits, reset 0).
  - A step-enable fires once every PSR+1 clocks while busy; the prescaler restarts on start.
  - Writes to PSR while busy are ignored and set err.
- Not defined: address 6 reads 0, writes are ignored, and a step-enable fires every clock.

Test Plan:
- Reset mid-count: assert reset_in=0 asynchronously -> all outputs at reset values before the next edge, bus high-Z.
- Bounce: PLR=5, ULR=7, LLR=3, CCR=2, CTRL=0, start -> count 5,6,7,7,6,5,4,3,3,4,5 repeated twice; ec pulses once on the 22nd edge after start; busy falls with it.
- Wrap: PLR=2, ULR=4, LLR=1, CCR=1, CTRL=1 -> count 2,3,4,1,2, then ec; dir=1 throughout.
- Errors: PLR=9, ULR=7, start -> err=1, busy=0, count unchanged. Write ULR while busy -> ULR unchanged, err=1. Valid start afterwards -> err=0.
- CCR=0 and start -> single-clock ec, busy stays 0. Abort written at count=6 -> IDLE, count=6, no ec.
- Readback: write 0xA5 to PLR, then read addr 0 -> 0xA5 on data_in_out. Read addr 7 while counting -> 0x01 in bounce mode.
